// File: rtl/delay_chain.sv
// Parameterised shift/broadcast delay chain with fill tracking, tap select
// and rise/fall detection on bit 0 of the last stage.
module delay_chain #(
  parameter  int WIDTH = 1,
  parameter  int DEPTH = 3,
  localparam int SELW  = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       sig_in,
  input  logic                   shift_en,
  input  logic                   broadcast,
  input  logic                   flush,
  input  logic [SELW-1:0]        tap_sel,
  output logic [WIDTH*DEPTH-1:0] stage_out,
  output logic [WIDTH-1:0]       tap_out,
  output logic [SELW:0]          fill_count,
  output logic                   full,
  output logic                   rise,
  output logic                   fall
);

  localparam logic [SELW:0] DEPTH_W = (SELW+1)'(DEPTH);
  localparam logic [SELW:0] ONE_W   = (SELW+1)'(1);

  logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;
  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [SELW:0]               fill_q, fill_d;
  logic                        last_q, last_d;

  always_comb begin
    stage_d = stage_q;
    valid_d = valid_q;
    fill_d  = fill_q;
    last_d  = stage_q[DEPTH-1][0];
    if (flush) begin
      stage_d = '0;
      valid_d = '0;
      fill_d  = '0;
      last_d  = 1'b0;
    end else if (shift_en) begin
      if (broadcast) begin
        for (int unsigned i = 0; i < DEPTH; i++) stage_d[i] = sig_in;
        valid_d = '1;
        fill_d  = DEPTH_W;
      end else begin
        stage_d = {stage_q[DEPTH-2:0], sig_in};
        valid_d = {valid_q[DEPTH-2:0], 1'b1};
        // valid bits fill as a thermometer, so popcount is a saturating increment
        fill_d  = (fill_q == DEPTH_W) ? fill_q : fill_q + ONE_W;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= '0;
      valid_q <= '0;
      fill_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      stage_q <= stage_d;
      valid_q <= valid_d;
      fill_q  <= fill_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    tap_out = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (tap_sel == SELW'(i)) tap_out = stage_q[i];
    end
  end

  assign stage_out  = stage_q;
  assign fill_count = fill_q;
  assign full       = (fill_q == DEPTH_W);
  assign rise       = stage_q[DEPTH-1][0] & ~last_q;
  assign fall       = ~stage_q[DEPTH-1][0] & last_q;

endmodule

// File: tb/tb_delay_chain.sv
// Directed scoreboard bench for delay_chain: default 1x3 instance plus a
// 4-bit-wide instance for tap selection.
module tb_delay_chain;

  typedef struct packed {
    logic [2:0] stage;
    logic [1:0] fill;
    logic       full;
    logic       rise;
    logic       fall;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset, flush, shift_en, broadcast;
  logic        sig_a;
  logic [3:0]  sig_b;
  logic [1:0]  tap_sel_a, tap_sel_b;
  logic [2:0]  stage_out_a;
  logic        tap_out_a;
  logic [1:0]  fill_a, fill_b;
  logic        full_a, rise_a, fall_a;
  logic [11:0] stage_out_b;
  logic [3:0]  tap_out_b;
  logic        full_b, rise_b, fall_b;

  int checks = 0;
  int fails  = 0;
  obs_t exp_q[$];

  always #5 clk = ~clk;

  delay_chain #(.WIDTH(1), .DEPTH(3)) u_a (
    .clk(clk), .reset(reset), .sig_in(sig_a), .shift_en(shift_en),
    .broadcast(broadcast), .flush(flush), .tap_sel(tap_sel_a),
    .stage_out(stage_out_a), .tap_out(tap_out_a), .fill_count(fill_a),
    .full(full_a), .rise(rise_a), .fall(fall_a)
  );

  delay_chain #(.WIDTH(4), .DEPTH(3)) u_b (
    .clk(clk), .reset(reset), .sig_in(sig_b), .shift_en(shift_en),
    .broadcast(broadcast), .flush(flush), .tap_sel(tap_sel_b),
    .stage_out(stage_out_b), .tap_out(tap_out_b), .fill_count(fill_b),
    .full(full_b), .rise(rise_b), .fall(fall_b)
  );

  function automatic obs_t mk(input logic [2:0] s, input logic [1:0] f,
                              input logic r, input logic fa);
    obs_t e;
    e.stage = s;
    e.fill  = f;
    e.full  = (f == 2'd3);
    e.rise  = r;
    e.fall  = fa;
    return e;
  endfunction

  task automatic check_val(input string tag, input logic [11:0] o, input logic [11:0] e);
    checks++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  // Drive one edge of stimulus, queue the expected result, compare after the edge.
  task automatic step(input string tag, input logic rst, input logic fl,
                      input logic en, input logic bc, input logic sig,
                      input logic [3:0] sigb, input logic [2:0] es,
                      input logic [1:0] ef, input logic er, input logic efa);
    obs_t e, o;
    reset = rst; flush = fl; shift_en = en; broadcast = bc;
    sig_a = sig; sig_b = sigb;
    exp_q.push_back(mk(es, ef, er, efa));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    o.stage = stage_out_a;
    o.fill  = fill_a;
    o.full  = full_a;
    o.rise  = rise_a;
    o.fall  = fall_a;
    checks++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, o, e);
    end
  endtask

  initial begin
    tap_sel_a = 2'd0;
    tap_sel_b = 2'd0;

    //        tag        rst fl en bc sig sigb   stage   fill  r  f
    step("reset",        1, 0, 0, 0, 0, 4'h0, 3'b000, 2'd0, 0, 0);
    step("fill1",        0, 0, 1, 0, 1, 4'h0, 3'b001, 2'd1, 0, 0);
    step("fill2",        0, 0, 1, 0, 1, 4'h0, 3'b011, 2'd2, 0, 0);
    tap_sel_a = 2'd0; #1 check_val("tap_a0", {11'd0, tap_out_a}, 12'd1);
    tap_sel_a = 2'd1; #1 check_val("tap_a1", {11'd0, tap_out_a}, 12'd1);
    tap_sel_a = 2'd2; #1 check_val("tap_a2", {11'd0, tap_out_a}, 12'd0);
    tap_sel_a = 2'd3; #1 check_val("tap_a3", {11'd0, tap_out_a}, 12'd0);
    step("fill3_rise",   0, 0, 1, 0, 1, 4'h0, 3'b111, 2'd3, 1, 0);
    for (int i = 0; i < 5; i++)
      step("hold",       0, 0, 0, 0, 0, 4'h0, 3'b111, 2'd3, 0, 0);
    step("flush",        0, 1, 1, 0, 1, 4'h0, 3'b000, 2'd0, 0, 0);
    step("post_flush",   0, 0, 0, 0, 0, 4'h0, 3'b000, 2'd0, 0, 0);

    step("reset2",       1, 0, 0, 0, 0, 4'h0, 3'b000, 2'd0, 0, 0);
    step("bcast",        0, 0, 1, 1, 1, 4'h0, 3'b111, 2'd3, 1, 0);
    step("bcast_hold",   0, 0, 0, 1, 0, 4'h0, 3'b111, 2'd3, 0, 0);

    step("sat1",         0, 0, 1, 0, 0, 4'h0, 3'b110, 2'd3, 0, 0);
    step("sat2",         0, 0, 1, 0, 0, 4'h0, 3'b100, 2'd3, 0, 0);
    step("sat3_fall",    0, 0, 1, 0, 0, 4'h0, 3'b000, 2'd3, 0, 1);
    for (int i = 0; i < 7; i++)
      step("sat_tail",   0, 0, 1, 0, 0, 4'h0, 3'b000, 2'd3, 0, 0);

    step("reset3",       1, 0, 0, 0, 0, 4'h0, 3'b000, 2'd0, 0, 0);
    step("pre_rst1",     0, 0, 1, 0, 1, 4'h0, 3'b001, 2'd1, 0, 0);
    step("pre_rst2",     0, 0, 1, 0, 1, 4'h0, 3'b011, 2'd2, 0, 0);
    step("rst_priority", 1, 1, 1, 0, 1, 4'h0, 3'b000, 2'd0, 0, 0);

    step("mode_shift",   0, 0, 1, 0, 1, 4'h0, 3'b001, 2'd1, 0, 0);
    step("mode_bcast",   0, 0, 1, 1, 0, 4'h0, 3'b000, 2'd3, 0, 0);
    step("mode_back",    0, 0, 1, 0, 1, 4'h0, 3'b001, 2'd3, 0, 0);

    step("reset4",       1, 0, 0, 0, 0, 4'h0, 3'b000, 2'd0, 0, 0);
    step("tap_inA",      0, 0, 1, 0, 0, 4'hA, 3'b000, 2'd1, 0, 0);
    step("tap_inB",      0, 0, 1, 0, 0, 4'hB, 3'b000, 2'd2, 0, 0);
    step("tap_inC",      0, 0, 1, 0, 0, 4'hC, 3'b000, 2'd3, 0, 0);
    shift_en = 1'b0;
    check_val("stage_b", stage_out_b, 12'hABC);
    tap_sel_b = 2'd0; #1 check_val("tap_b0", {8'd0, tap_out_b}, 12'h00C);
    tap_sel_b = 2'd1; #1 check_val("tap_b1", {8'd0, tap_out_b}, 12'h00B);
    tap_sel_b = 2'd2; #1 check_val("tap_b2", {8'd0, tap_out_b}, 12'h00A);
    tap_sel_b = 2'd3; #1 check_val("tap_b3", {8'd0, tap_out_b}, 12'h000);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/delay_chain.md
DELAY_CHAIN -- requirements
Module: delay_chain

Interface
REQ-001 Parameter WIDTH, default 1, SHALL set the bit width of each stage; legal range is 1 or more.
REQ-002 Parameter DEPTH, default 3, SHALL set the number of stages; legal range is 2 to 16.
REQ-003 Parameter SELW SHALL be a localparam equal to $clog2(DEPTH); it is the tap select width.
REQ-004 The ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- sig_in  in  WIDTH  data entering stage 0.
- shift_en  in  1  advance (or broadcast) on this edge; hold when low.
- broadcast  in  1  mode select: 0 = shift chain, 1 = load every stage with sig_in in one edge.
- flush  in  1  synchronous clear of data and valid state.
- tap_sel  in  SELW  index of the stage driven onto tap_out.
- stage_out  out  WIDTH*DEPTH  all stages; stage i at bits [i*WIDTH +: WIDTH].
- tap_out  out  WIDTH  selected stage.
- fill_count  out  SELW+1  number of valid stages, 0..DEPTH.
- full  out  1  fill_count == DEPTH.
- rise  out  1  one-cycle pulse when bit 0 of stage DEPTH-1 goes 0->1.
- fall  out  1  one-cycle pulse when bit 0 of stage DEPTH-1 goes 1->0.

Function
REQ-005 Edge priority SHALL be: reset, then flush, then shift_en, then hold.
REQ-006 Flush SHALL behave as follows:
- Applies when flush=1 and reset=0.
- All stages, per-stage valid bits, fill_count and the edge-history register clear to 0.
- shift_en and broadcast are ignored on that edge.
REQ-007 When shift_en=1 and broadcast=0, the chain SHALL shift:
- stage[0] <= sig_in, and stage[i] <= stage[i-1] for i = 1..DEPTH-1, using the pre-edge values of all stages.
- valid[0] <= 1, and valid[i] <= valid[i-1].
REQ-008 When shift_en=1 and broadcast=1, every stage SHALL load sig_in on that single edge and every valid bit SHALL set to 1.
REQ-009 When shift_en=0 (and no reset or flush), all stages, valid bits and fill_count SHALL hold.
REQ-010 fill_count SHALL be a registered value equal to the population count of the valid bits after each edge:
- Shift: saturating +1, clamped at DEPTH.
- Broadcast: set to DEPTH.
- Flush or reset: set to 0.
REQ-011 full SHALL be combinational from fill_count.
REQ-012 In shift mode, latency from sig_in to stage k SHALL be k+1 enabled edges; in broadcast mode it SHALL be 1 edge for every stage.
REQ-013 tap_out SHALL be a combinational selection of stage[tap_sel]; if tap_sel >= DEPTH, tap_out SHALL be 0.
REQ-014 The edge detector SHALL work as follows:
- Register last_q <= stage[DEPTH-1][0] on every edge.
- rise = stage[DEPTH-1][0] & ~last_q.
- fall = ~stage[DEPTH-1][0] & last_q.
- Both outputs are combinational from registers only and cannot assert together.
REQ-015 Because flush clears last_q together with the stages, flush SHALL NOT produce a fall pulse.
REQ-016 A mode change between consecutive enabled edges SHALL take effect on the edge where the new value of broadcast is sampled, with no extra latency.
REQ-017 No output SHALL depend combinationally on sig_in, shift_en, broadcast or flush.

Reset
REQ-018 With reset=1 at a rising edge, the block SHALL behave as follows:
- All stages, valid bits, fill_count and last_q go to 0.
- Outputs then read stage_out=0, tap_out=0, fill_count=0, full=0, rise=0, fall=0.
REQ-019 Reset asserted mid-fill or together with flush or shift_en SHALL take precedence and produce the REQ-018 state on that edge.
REQ-020 After reset is released, the first enabled edge SHALL behave exactly as the first edge out of power-up.

Verification (defaults WIDTH=1, DEPTH=3)
REQ-021 Shift fill: reset, then sig_in=1 with shift_en=1 for 3 edges:
- stage_out goes 001 -> 011 -> 111.
- fill_count goes 1 -> 2 -> 3.
- full=1 after edge 3.
- rise pulses for exactly one cycle after edge 3.
REQ-022 Broadcast: reset, then broadcast=1, shift_en=1, sig_in=1 for one edge -> stage_out=111, fill_count=3, full=1, and rise pulses for one cycle.
REQ-023 Hold and flush:
- Hold: from stage_out=111, shift_en=0 for 5 edges -> no change to any output.
- Flush: then flush=1 with shift_en=1 -> stage_out=000, fill_count=0, and fall never asserts.
REQ-024 Saturation and falling edge: 10 shift edges with sig_in=0 after a full load of 1s:
- fill_count stays at 3.
- stage_out goes 110 -> 100 -> 000.
- fall pulses once, after the third edge.
REQ-025 Tap select: with WIDTH=4, DEPTH=3, shift in 0xA, 0xB, 0xC:
- tap_sel=0 gives 0xC, 1 gives 0xB, 2 gives 0xA.
- tap_sel=3 gives 0x0.
REQ-026 Reset priority: assert reset together with shift_en=1 and flush=1 at fill_count=2 -> all outputs 0 on the next cycle.
